down_counter_timer: RTL and testbench

- Loadable N-bit down-counter with terminal-count detection.
- Counts toward zero; raises a sticky interrupt request, cleared by an acknowledge handshake; supports one-shot and auto-reload modes.
- Sits beside the SAYAC up-counter in the peripheral/controller datapath and serves as the countdown timer for delay and timeout generation.

---
 rtl/down_counter_timer_pkg.sv | 19 +
 rtl/down_counter_timer_tc_flag.sv | 53 +++++
 rtl/down_counter_timer.sv | 130 +++++++++++++
 tb/tb_down_counter_timer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/down_counter_timer_pkg.sv
// ---------------------------------------------------------------------------
// down_counter_timer_pkg
// Shared SAYAC definitions for the countdown timer: FSM state encoding and
// the default counter/reload width.
// ---------------------------------------------------------------------------
package down_counter_timer_pkg;

  // Default width of the counter and the reload register.
  localparam int unsigned DCT_WIDTH = 16;

  // Timer FSM states. The encodings are fixed so that other SAYAC blocks and
  // checkers can decode them.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } dct_state_e;

endpackage : down_counter_timer_pkg

// File: rtl/down_counter_timer_tc_flag.sv
// ---------------------------------------------------------------------------
// down_counter_timer_tc_flag
// Sticky terminal-count request (irq) and overflow (ovf) flags.
//
// Ports:
//   clk    - rising-edge clock
//   rst    - synchronous active-high reset, clears both flags
//   set_i  - terminal event this cycle
//   clr_i  - acknowledge, clears irq and ovf
//   irq_o  - sticky terminal-count request
//   ovf_o  - sticky, a terminal event arrived while irq was already set
//
// A set in the same cycle as a clear wins for irq. ovf is not raised in that
// case, because the previous request is being acknowledged on this edge.
// ---------------------------------------------------------------------------
module down_counter_timer_tc_flag (
  input  logic clk,
  input  logic rst,
  input  logic set_i,
  input  logic clr_i,
  output logic irq_o,
  output logic ovf_o
);

  logic irq_q, irq_d;
  logic ovf_q, ovf_d;

  always_comb begin
    irq_d = irq_q;
    ovf_d = ovf_q;
    if (set_i) begin
      irq_d = 1'b1;
      ovf_d = clr_i ? 1'b0 : (ovf_q | irq_q);
    end else if (clr_i) begin
      irq_d = 1'b0;
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
      ovf_q <= ovf_d;
    end
  end

  assign irq_o = irq_q;
  assign ovf_o = ovf_q;

endmodule : down_counter_timer_tc_flag

// File: rtl/down_counter_timer.sv
// ---------------------------------------------------------------------------
// down_counter_timer
// Loadable N-bit down-counter with terminal-count detection, sticky irq/ovf
// and one-shot / auto-reload modes. Countdown timer for SAYAC delay and
// timeout generation.
//
// Ports:
//   clk        - rising-edge clock
//   rst        - synchronous active-high reset
//   initValue  - value loaded into counter and reload register
//   iniCnt     - load strobe, starts a countdown
//   decCnt     - decrement tick
//   stopCnt    - abort countdown (RUN only), count holds
//   autoReload - 1 = auto-reload, 0 = one-shot; captured with iniCnt
//   irqAck     - clears irq and ovf
//   dataOut    - current count
//   bo         - borrow/zero flag, (dataOut == 0), combinational
//   running    - state is RUN
//   irq        - sticky terminal-count request
//   ovf        - sticky, terminal event while irq already set
//
// Input priority in every state: rst > iniCnt > stopCnt > decCnt.
// ---------------------------------------------------------------------------
module down_counter_timer
  import down_counter_timer_pkg::*;
#(
  parameter int unsigned N = DCT_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] initValue,
  input  logic         iniCnt,
  input  logic         decCnt,
  input  logic         stopCnt,
  input  logic         autoReload,
  input  logic         irqAck,
  output logic [N-1:0] dataOut,
  output logic         bo,
  output logic         running,
  output logic         irq,
  output logic         ovf
);

  localparam logic [N-1:0] ZERO = '0;
  localparam logic [N-1:0] ONE  = {{(N-1){1'b0}}, 1'b1};

  dct_state_e   state_q, state_d;
  logic [N-1:0] cnt_q, cnt_d;
  logic [N-1:0] reload_q, reload_d;
  logic         mode_q, mode_d;
  logic         term_evt;

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= ZERO;
      reload_q <= ZERO;
      mode_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      mode_q   <= mode_d;
    end
  end

  // Next-state and next-count logic. term_evt marks the edge on which the
  // count reaches zero (or reloads), or a zero value is loaded.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    reload_d = reload_q;
    mode_d   = mode_q;
    term_evt = 1'b0;
    if (iniCnt) begin
      cnt_d    = initValue;
      reload_d = initValue;
      mode_d   = autoReload;
      if (initValue == ZERO) begin
        state_d  = DONE;
        term_evt = 1'b1;
      end else begin
        state_d  = RUN;
      end
    end else begin
      case (state_q)
        RUN: begin
          if (stopCnt) begin
            state_d = IDLE;
          end else if (decCnt) begin
            if (cnt_q > ONE) begin
              cnt_d = cnt_q - ONE;
            end else begin
              // RUN is only entered with a nonzero count, so this is the
              // 1 -> terminal step; 0 never decrements and never wraps.
              term_evt = 1'b1;
              if (mode_q) begin
                cnt_d = reload_q;
              end else begin
                cnt_d   = ZERO;
                state_d = DONE;
              end
            end
          end
        end
        IDLE:    state_d = IDLE;
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output logic.
  always_comb begin
    running = (state_q == RUN);
    bo      = (cnt_q == ZERO);
    dataOut = cnt_q;
  end

  down_counter_timer_tc_flag u_tc_flag (
    .clk   (clk),
    .rst   (rst),
    .set_i (term_evt),
    .clr_i (irqAck),
    .irq_o (irq),
    .ovf_o (ovf)
  );

endmodule : down_counter_timer

// File: tb/tb_down_counter_timer.sv
// ---------------------------------------------------------------------------
// tb_down_counter_timer
// Directed scenarios plus randomized traffic, compared every cycle against a
// behavioural model of the timer.
// ---------------------------------------------------------------------------
module tb_down_counter_timer;

  localparam int N = 16;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [N-1:0] initValue;
  logic         iniCnt, decCnt, stopCnt, autoReload, irqAck;
  logic [N-1:0] dataOut;
  logic         bo, running, irq, ovf;

  down_counter_timer #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .initValue  (initValue),
    .iniCnt     (iniCnt),
    .decCnt     (decCnt),
    .stopCnt    (stopCnt),
    .autoReload (autoReload),
    .irqAck     (irqAck),
    .dataOut    (dataOut),
    .bo         (bo),
    .running    (running),
    .irq        (irq),
    .ovf        (ovf)
  );

  // scoreboard counters
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // behavioural model
  typedef enum int {M_IDLE, M_RUN, M_DONE} m_phase_e;
  m_phase_e m_phase;
  int       m_cnt, m_reload;
  bit       m_auto, m_irq, m_ovf;

  task automatic model_step(input bit r, input bit ini, input int iv, input bit ar,
                            input bit dec, input bit stp, input bit ack);
    bit fire;
    fire = 0;
    if (r) begin
      m_phase = M_IDLE; m_cnt = 0; m_reload = 0; m_auto = 0; m_irq = 0; m_ovf = 0;
      return;
    end
    if (ini) begin
      m_cnt = iv; m_reload = iv; m_auto = ar;
      if (iv == 0) begin m_phase = M_DONE; fire = 1; end
      else m_phase = M_RUN;
    end else if (m_phase == M_RUN && stp) begin
      m_phase = M_IDLE;
    end else if (m_phase == M_RUN && dec) begin
      if (m_cnt == 1) begin
        fire = 1;
        if (m_auto) m_cnt = m_reload;
        else begin m_cnt = 0; m_phase = M_DONE; end
      end else begin
        m_cnt = m_cnt - 1;
      end
    end
    if (fire) begin
      if (ack) m_ovf = 0;
      else if (m_irq) m_ovf = 1;
      m_irq = 1;
    end else if (ack) begin
      m_irq = 0; m_ovf = 0;
    end
  endtask

  task automatic compare_model();
    chk("cnt",  {16'h0, dataOut}, m_cnt);
    chk("bo",   {31'h0, bo},      (m_cnt == 0));
    chk("run",  {31'h0, running}, (m_phase == M_RUN));
    chk("irq",  {31'h0, irq},     m_irq);
    chk("ovf",  {31'h0, ovf},     m_ovf);
  endtask

  // driver: apply one cycle of inputs, advance the model, compare after edge
  task automatic step(input bit r, input bit ini, input int iv, input bit ar,
                      input bit dec, input bit stp, input bit ack);
    rst = r; iniCnt = ini; initValue = iv[N-1:0]; autoReload = ar;
    decCnt = dec; stopCnt = stp; irqAck = ack;
    @(posedge clk);
    model_step(r, ini, iv, ar, dec, stp, ack);
    #1;
    compare_model();
  endtask

  task automatic idle_step();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    step(0, 0, 0, 0, 1, 0, 0);
  endtask

  initial begin
    rst = 1; iniCnt = 0; initValue = '0; autoReload = 0;
    decCnt = 0; stopCnt = 0; irqAck = 0;
    m_phase = M_IDLE; m_cnt = 0; m_reload = 0; m_auto = 0; m_irq = 0; m_ovf = 0;

    // reset state
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("rst_cnt", {16'h0, dataOut}, 0);
    chk("rst_bo",  {31'h0, bo}, 1);
    chk("rst_run", {31'h0, running}, 0);
    chk("rst_irq", {31'h0, irq}, 0);

    // one-shot: load 3, tick x3, extra tick holds at 0
    step(0, 1, 3, 0, 0, 0, 0);
    chk("os_load", {16'h0, dataOut}, 3);
    chk("os_run",  {31'h0, running}, 1);
    tick(); chk("os_t1", {16'h0, dataOut}, 2);
    tick(); chk("os_t2", {16'h0, dataOut}, 1);
    chk("os_irq_early", {31'h0, irq}, 0);
    tick(); chk("os_t3", {16'h0, dataOut}, 0);
    chk("os_irq", {31'h0, irq}, 1);
    chk("os_bo",  {31'h0, bo}, 1);
    chk("os_done_run", {31'h0, running}, 0);
    tick(); chk("os_t4_hold", {16'h0, dataOut}, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("os_ack", {31'h0, irq}, 0);

    // auto-reload: load 2, six ticks -> 1,2,1,2,1,2
    step(0, 1, 2, 1, 0, 0, 0);
    chk("ar_load", {16'h0, dataOut}, 2);
    tick(); chk("ar_t1", {16'h0, dataOut}, 1);
    chk("ar_t1_irq", {31'h0, irq}, 0);
    tick(); chk("ar_t2", {16'h0, dataOut}, 2);
    chk("ar_t2_irq", {31'h0, irq}, 1);
    chk("ar_t2_ovf", {31'h0, ovf}, 0);
    tick(); chk("ar_t3", {16'h0, dataOut}, 1);
    tick(); chk("ar_t4", {16'h0, dataOut}, 2);
    chk("ar_t4_ovf", {31'h0, ovf}, 1);
    tick(); chk("ar_t5", {16'h0, dataOut}, 1);
    tick(); chk("ar_t6", {16'h0, dataOut}, 2);
    chk("ar_t6_run", {31'h0, running}, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("ar_ack_irq", {31'h0, irq}, 0);
    chk("ar_ack_ovf", {31'h0, ovf}, 0);

    // set-wins: dataOut=1, irq=1, decCnt + irqAck together
    tick(); chk("sw_pre", {16'h0, dataOut}, 1);
    tick(); chk("sw_irq_set", {31'h0, irq}, 1);
    tick(); chk("sw_pre2", {16'h0, dataOut}, 1);
    step(0, 0, 0, 0, 1, 0, 1);
    chk("sw_irq", {31'h0, irq}, 1);
    chk("sw_ovf", {31'h0, ovf}, 0);
    chk("sw_cnt", {16'h0, dataOut}, 2);
    step(0, 0, 0, 0, 0, 0, 1);

    // zero load
    step(0, 1, 0, 0, 0, 0, 0);
    chk("zl_irq", {31'h0, irq}, 1);
    chk("zl_bo",  {31'h0, bo}, 1);
    chk("zl_run", {31'h0, running}, 0);
    tick(); chk("zl_hold", {16'h0, dataOut}, 0);
    step(0, 0, 0, 0, 0, 1, 1);

    // priority: iniCnt beats stopCnt and decCnt; stopCnt beats decCnt
    step(0, 1, 5, 0, 0, 0, 0);
    chk("pr_five", {16'h0, dataOut}, 5);
    step(0, 1, 9, 0, 1, 1, 0);
    chk("pr_ini_cnt", {16'h0, dataOut}, 9);
    chk("pr_ini_run", {31'h0, running}, 1);
    step(0, 0, 0, 0, 1, 1, 0);
    chk("pr_stop_cnt", {16'h0, dataOut}, 9);
    chk("pr_stop_run", {31'h0, running}, 0);
    tick(); chk("pr_idle_hold", {16'h0, dataOut}, 9);

    // maximum load
    step(0, 1, 16'hFFFF, 0, 0, 0, 0);
    tick(); chk("max_t1", {16'h0, dataOut}, 32'hFFFE);

    // reset mid-count: reset is synchronous, nothing moves before the edge
    step(0, 1, 8, 0, 0, 0, 0);
    tick(); chk("rm_seven", {16'h0, dataOut}, 7);
    rst = 1; decCnt = 1; iniCnt = 0; stopCnt = 0; irqAck = 0;
    #1;
    chk("rm_pre_edge", {16'h0, dataOut}, 7);
    chk("rm_pre_run",  {31'h0, running}, 1);
    step(1, 0, 0, 0, 1, 0, 0);
    chk("rm_cnt", {16'h0, dataOut}, 0);
    chk("rm_run", {31'h0, running}, 0);
    chk("rm_irq", {31'h0, irq}, 0);
    chk("rm_ovf", {31'h0, ovf}, 0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      bit r, ini, ar, dec, stp, ack;
      int iv;
      r   = ($urandom_range(0, 99) == 0);
      ini = ($urandom_range(0, 11) == 0);
      ar  = $urandom_range(0, 1);
      dec = ($urandom_range(0, 1) == 1);
      stp = ($urandom_range(0, 15) == 0);
      ack = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 9) == 0) iv = $urandom_range(0, 16'hFFFF);
      else iv = $urandom_range(0, 6);
      step(r, ini, iv, ar, dec, stp, ack);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_down_counter_timer
